// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data RAM between the core load/store path and the
// compression engine: CPU has priority, a wait counter forces engine grants.
module dmem_port_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_mem_read,
   input  logic              cpu_mem_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              eng_req,
   input  logic              eng_we,
   input  logic [ADDR_W-1:0] eng_addr,
   input  logic [DATA_W-1:0] eng_wdata,
   output logic              eng_gnt,
   output logic              eng_rvalid,
   output logic [DATA_W-1:0] eng_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, CPU_RD, ENG_RD} state_t;

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   state_t            state;
   logic [3:0]        wait_cnt;
   logic [DATA_W-1:0] cpu_rdata_q, eng_rdata_q;
   logic              cpu_req, eng_win, cpu_win;

   // Arbitration only in IDLE; a simultaneous read+write counts as a write.
   always_comb begin
      cpu_req = cpu_mem_read | cpu_mem_write;
      eng_win = !rst && (state == IDLE) && eng_req && ((wait_cnt == MAX_W) || !cpu_req);
      cpu_win = !rst && (state == IDLE) && cpu_req && !eng_win;
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      if (eng_win) begin
         mem_addr  = eng_addr;
         mem_wdata = eng_wdata;
         mem_we    = eng_we;
         mem_re    = !eng_we;
      end else if (cpu_win) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_mem_write;
         mem_re    = !cpu_mem_write;
      end
      eng_gnt    = eng_win;
      eng_rvalid = !rst && (state == ENG_RD);
      // A granted store finishes in one cycle; everything else in IDLE/ENG_RD waits.
      cpu_stall  = !rst && cpu_req &&
                   ((state == ENG_RD) || ((state == IDLE) && !(cpu_win && cpu_mem_write)));
      cpu_rdata  = rst ? '0 : ((state == CPU_RD) ? mem_rdata : cpu_rdata_q);
      eng_rdata  = rst ? '0 : ((state == ENG_RD) ? mem_rdata : eng_rdata_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         cpu_rdata_q <= '0;
         eng_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (eng_win && !eng_we)
                  state <= ENG_RD;
               else if (cpu_win && !cpu_mem_write)
                  state <= CPU_RD;
            end
            default: state <= IDLE;
         endcase
         if (state == CPU_RD) cpu_rdata_q <= mem_rdata;
         if (state == ENG_RD) eng_rdata_q <= mem_rdata;
         if (!eng_req || eng_win)
            wait_cnt <= '0;
         else if (wait_cnt != MAX_W)
            wait_cnt <= wait_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a behavioural sync RAM,
// a shadow memory model and a queue of expected engine read data.
module tb_dmem_port_arbiter;
   localparam int AW = 16, DW = 32, MW = 4;

   logic          clk = 1'b0, rst;
   logic          cpu_mem_read, cpu_mem_write, cpu_stall;
   logic [AW-1:0] cpu_addr, eng_addr, mem_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata, eng_wdata, eng_rdata, mem_wdata, mem_rdata;
   logic          eng_req, eng_we, eng_gnt, eng_rvalid, mem_we, mem_re;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
      .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata)
   );

   logic [DW-1:0] ram [256];
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] eng_q [$];
   int checks = 0, errors = 0;

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'hA5A50000 ^ (i * 32'h01030507);
   end

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr[7:0]];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, act, exp);
      end
   endtask

   // Scoreboard: every eng_rvalid pops one expected word.
   always @(negedge clk) begin
      if (eng_rvalid) begin
         if (eng_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL eng_rvalid_unexpected got 1 exp 0");
         end else chk("eng_rdata", eng_rdata, eng_q.pop_front());
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle_in();
      cpu_mem_read = 0; cpu_mem_write = 0; eng_req = 0; eng_we = 0;
   endtask

   task automatic cpu_load(input logic [AW-1:0] a, input string nm);
      int re_cnt;
      re_cnt = 0;
      cpu_mem_read = 1; cpu_addr = a;
      @(negedge clk);
      re_cnt += int'(mem_re);
      chk({nm, "_issue_re"}, mem_re, 1);
      chk({nm, "_issue_stall"}, cpu_stall, 1);
      step();
      @(negedge clk);
      re_cnt += int'(mem_re);
      chk({nm, "_data_stall"}, cpu_stall, 0);
      chk({nm, "_rdata"}, cpu_rdata, ref_mem[a[7:0]]);
      chk({nm, "_re_pulses"}, re_cnt, 1);
      step();
      cpu_mem_read = 0;
   endtask

   typedef struct {
      bit crd, cwr, ereq, ewe;
      bit xwe, xre, xstall, xgnt;
   } vec_t;
   vec_t vecs [8];

   initial begin
      logic [AW-1:0] xaddr;
      logic [DW-1:0] exp_data;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA5A50000 ^ (i * 32'h01030507);
      vecs[0] = '{0,0,0,0, 0,0,0,0};
      vecs[1] = '{1,0,0,0, 0,1,1,0};
      vecs[2] = '{0,1,0,0, 1,0,0,0};
      vecs[3] = '{1,1,0,0, 1,0,0,0};
      vecs[4] = '{0,0,1,0, 0,1,0,1};
      vecs[5] = '{0,0,1,1, 1,0,0,1};
      vecs[6] = '{0,1,1,0, 1,0,0,0};
      vecs[7] = '{1,0,1,1, 0,1,1,0};

      // Reset values, including with requests present during reset
      idle_in(); rst = 1; cpu_addr = 0; cpu_wdata = 0; eng_addr = 0; eng_wdata = 0;
      step(); step();
      cpu_mem_read = 1; eng_req = 1; cpu_addr = 16'h0011; eng_addr = 16'h0022;
      @(negedge clk);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_eng_gnt", eng_gnt, 0);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      step();
      rst = 0; idle_in();
      step();

      // Single-cycle arbitration table from IDLE with wait_cnt=0
      foreach (vecs[i]) begin
         cpu_mem_read = vecs[i].crd; cpu_mem_write = vecs[i].cwr;
         eng_req = vecs[i].ereq; eng_we = vecs[i].ewe;
         cpu_addr = 16'h0040 + 16'(i); eng_addr = 16'h0080 + 16'(i);
         cpu_wdata = 32'h1000_0000 + i; eng_wdata = 32'h2000_0000 + i;
         xaddr = vecs[i].xgnt ? eng_addr : ((vecs[i].crd | vecs[i].cwr) ? cpu_addr : '0);
         @(negedge clk);
         chk($sformatf("vec%0d_we", i), mem_we, vecs[i].xwe);
         chk($sformatf("vec%0d_re", i), mem_re, vecs[i].xre);
         chk($sformatf("vec%0d_stall", i), cpu_stall, vecs[i].xstall);
         chk($sformatf("vec%0d_gnt", i), eng_gnt, vecs[i].xgnt);
         chk($sformatf("vec%0d_addr", i), mem_addr, xaddr);
         if (vecs[i].xwe) ref_mem[xaddr[7:0]] = vecs[i].xgnt ? eng_wdata : cpu_wdata;
         if (vecs[i].xgnt && !vecs[i].ewe) eng_q.push_back(ref_mem[xaddr[7:0]]);
         step(); idle_in(); step(); step();
      end

      // CPU store then load-back
      cpu_mem_write = 1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("st_we", mem_we, 1);
      chk("st_addr", mem_addr, 16'h0010);
      chk("st_stall", cpu_stall, 0);
      ref_mem[8'h10] = 32'hDEADBEEF;
      step(); idle_in();
      cpu_load(16'h0010, "ld10");
      @(negedge clk);
      chk("ld10_hold", cpu_rdata, 32'hDEADBEEF);
      step();

      // Engine read alone
      eng_req = 1; eng_we = 0; eng_addr = 16'h0020;
      @(negedge clk);
      chk("er_gnt", eng_gnt, 1);
      chk("er_re", mem_re, 1);
      eng_q.push_back(ref_mem[8'h20]);
      step(); eng_req = 0;
      @(negedge clk);
      chk("er_gnt_once", eng_gnt, 0);
      chk("er_rvalid", eng_rvalid, 1);
      step();
      @(negedge clk);
      chk("er_rvalid_pulse", eng_rvalid, 0);
      step();

      // Starvation: continuous stores, engine write held
      eng_req = 1; eng_we = 1; eng_addr = 16'h0030; eng_wdata = 32'hCAFE0030;
      begin
         int n;
         n = 0;
         for (int k = 0; k < 6; k++) begin
            cpu_mem_write = 1; cpu_addr = 16'h0050 + 16'(n); cpu_wdata = 32'h5000_0000 + n;
            @(negedge clk);
            chk($sformatf("sv%0d_gnt", k), eng_gnt, (k == 4));
            chk($sformatf("sv%0d_stall", k), cpu_stall, (k == 4));
            chk($sformatf("sv%0d_addr", k), mem_addr, (k == 4) ? 16'h0030 : cpu_addr);
            chk($sformatf("sv%0d_we", k), mem_we, 1);
            if (k == 4) ref_mem[8'h30] = eng_wdata;
            else begin
               ref_mem[cpu_addr[7:0]] = cpu_wdata;
               n++;
            end
            step();
            if (k == 4) eng_req = 0;
         end
      end
      idle_in();
      cpu_load(16'h0030, "ld30");
      cpu_load(16'h0054, "ld54");

      // Simultaneous CPU load and engine read: CPU first
      cpu_mem_read = 1; cpu_addr = 16'h0010; eng_req = 1; eng_we = 0; eng_addr = 16'h0020;
      @(negedge clk);
      chk("sim0_re", mem_re, 1);
      chk("sim0_stall", cpu_stall, 1);
      chk("sim0_gnt", eng_gnt, 0);
      step();
      @(negedge clk);
      chk("sim1_stall", cpu_stall, 0);
      chk("sim1_rdata", cpu_rdata, ref_mem[8'h10]);
      chk("sim1_re", mem_re, 0);
      chk("sim1_gnt", eng_gnt, 0);
      step(); cpu_mem_read = 0;
      @(negedge clk);
      chk("sim2_gnt", eng_gnt, 1);
      chk("sim2_addr", mem_addr, 16'h0020);
      eng_q.push_back(ref_mem[8'h20]);
      step(); eng_req = 0;
      @(negedge clk);
      chk("sim3_rvalid", eng_rvalid, 1);
      step();

      // Reset during CPU_RD
      cpu_mem_read = 1; cpu_addr = 16'h0041;
      step();
      rst = 1;
      @(negedge clk);
      chk("rcpu_stall", cpu_stall, 0);
      chk("rcpu_rdata", cpu_rdata, 0);
      step(); rst = 0; cpu_mem_read = 0;
      @(negedge clk);
      chk("rcpu_post_re", mem_re, 0);
      chk("rcpu_post_stall", cpu_stall, 0);
      chk("rcpu_post_rdata", cpu_rdata, 0);
      step();

      // Reset during ENG_RD: the read is dropped
      eng_req = 1; eng_we = 0; eng_addr = 16'h0022;
      @(negedge clk);
      chk("reng_gnt", eng_gnt, 1);
      step(); eng_req = 0; rst = 1;
      @(negedge clk);
      chk("reng_rvalid", eng_rvalid, 0);
      step(); rst = 0;
      @(negedge clk);
      chk("reng_post_rvalid", eng_rvalid, 0);
      chk("reng_post_rdata", eng_rdata, 0);
      chk("reng_post_gnt", eng_gnt, 0);
      step(); step();

      checks++;
      if (eng_q.size() != 0) begin
         errors++;
         $display("FAIL eng_q_drain got %0d exp 0", eng_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the processor's single-port synchronous data memory between two requesters: the core's load/store path (driven by the decoded MemRead/MemWrite) and the compressor/decompressor engine.
- Fixed priority to the CPU, with a starvation guard that forces an engine grant.
- Generates the CPU stall needed for the one-cycle read latency.
- Sits between the core datapath, the engine and the data RAM.

Parameters:
- ADDR_W, 16, address width of the data memory.
- DATA_W, 32, data word width.
- MAX_WAIT, 4, consecutive ungranted engine-request cycles before the engine overrides the CPU (range 1..15).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- cpu_mem_read  in  1  core load request (level, held while stalled)
- cpu_mem_write  in  1  core store request (level)
- cpu_addr  in  ADDR_W  core address
- cpu_wdata  in  DATA_W  core store data
- cpu_rdata  out  DATA_W  load data to core
- cpu_stall  out  1  freeze core PC/pipeline this cycle
- eng_req  in  1  engine access request (held until eng_gnt)
- eng_we  in  1  engine op: 1 write, 0 read
- eng_addr  in  ADDR_W  engine address
- eng_wdata  in  DATA_W  engine write data
- eng_gnt  out  1  one-cycle pulse: engine access issued
- eng_rvalid  out  1  one-cycle pulse: eng_rdata valid
- eng_rdata  out  DATA_W  engine read data
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_re

Behaviour:
- Reset:
  - State goes to IDLE and wait_cnt to 0.
  - While rst=1: eng_gnt=0, eng_rvalid=0, cpu_stall=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, eng_rdata=0.
- States: IDLE, CPU_RD (CPU read data cycle), ENG_RD (engine read data cycle).
- Arbitration happens only in IDLE. Issue decisions and mem_* outputs are combinational from state and requests.
- Grant decision in IDLE:
  - Engine wins if eng_req=1 and (wait_cnt==MAX_WAIT, or no CPU request).
  - Otherwise the CPU wins if it has a request.
- If cpu_mem_read=1 and cpu_mem_write=1 together, treat as a write.
- CPU write grant: mem_we=1, mem_addr/mem_wdata from CPU, cpu_stall=0 (single cycle). Stay in IDLE.
- CPU read grant: mem_re=1, cpu_stall=1, next state CPU_RD.
- CPU_RD:
  - cpu_rdata=mem_rdata and cpu_stall=0, so the core completes the load.
  - The CPU request still visible this cycle is ignored (no reissue).
  - No new issue this cycle; return to IDLE.
- Engine grant:
  - eng_gnt=1, mem_* from the engine, wait_cnt cleared.
  - If a CPU request is pending it is not issued and cpu_stall=1.
  - Write: stay in IDLE. Read: next state ENG_RD.
- ENG_RD:
  - eng_rdata=mem_rdata and eng_rvalid=1.
  - cpu_stall=1 if a CPU request is present; no issue.
  - Return to IDLE.
- CPU request present in IDLE but not granted → cpu_stall=1.
- No request in any state → mem_we=mem_re=0 and cpu_stall=0.
- wait_cnt:
  - Increments when eng_req=1 and eng_gnt=0, saturating at MAX_WAIT.
  - Clears on eng_gnt or eng_req=0.
- cpu_rdata and eng_rdata hold their last value outside their data cycles.
- Reset mid-read: the outstanding read is dropped; no eng_rvalid and no CPU data cycle after rst.
- Engine must not change eng_addr/eng_we/eng_wdata while eng_req=1 and eng_gnt=0.

Test Plan:
- CPU store alone (cpu_mem_write=1, addr 0x0010, data 0xDEADBEEF) → same cycle mem_we=1, mem_addr=0x0010, cpu_stall=0; a later load of 0x0010 returns 0xDEADBEEF.
- CPU load alone → cycle 0: mem_re=1, cpu_stall=1. Cycle 1: cpu_stall=0, cpu_rdata equals RAM word. Exactly one mem_re pulse.
- Engine read alone (eng_req=1, eng_we=0, addr 0x0020) → eng_gnt pulse in cycle 0, eng_rvalid pulse with the RAM word in cycle 1, eng_gnt never twice.
- Starvation (MAX_WAIT=4):
  - Stimulus: continuous CPU stores plus eng_req=1 held.
  - Required: engine denied 4 cycles; eng_gnt in the 5th cycle with cpu_stall=1 that cycle; the CPU store completes the next cycle.
- Simultaneous CPU load and engine read with wait_cnt=0 → CPU issued first (2 cycles), engine granted in cycle 2, eng_rvalid in cycle 3.
- rst asserted in CPU_RD and in ENG_RD → next cycle state IDLE, all outputs at reset values, no eng_rvalid.
